// File: rtl/gpu_rect_loader_pkg.sv
// gpu_rect_loader_pkg
// Shared constants and types for the rectangle-attribute loader.
// Contents: rectangle/field geometry, data and address widths, the
// base address of the rectangle table, the field index enum, the
// loader state enum and a one-hot helper for the bank write enables.
package gpu_rect_loader_pkg;

  localparam int RECT_COUNT       = 64;
  localparam int RECT_COUNT_WIDTH = 6;
  localparam int FIELDS           = 5;
  localparam int FIELD_WIDTH      = $clog2(FIELDS);
  localparam int DATA_WIDTH       = 16;
  localparam int MEM_ADDR_WIDTH   = 16;

  localparam logic [MEM_ADDR_WIDTH-1:0] GPU_RECT_BASE = 16'hF000;

  typedef enum logic [FIELD_WIDTH-1:0] {
    F_X, F_Y, F_W, F_H, F_COLOR
  } field_e;

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, FIN
  } load_state_e;

  function automatic logic [FIELDS-1:0] field_onehot(input field_e f);
    return FIELDS'(1) << f;
  endfunction

endpackage

// File: rtl/gpu_rect_loader_if.sv
// gpu_rect_loader_if
// Bus bundle between the loader, the data-memory read port and the
// five attribute banks.
// master (loader): drives mem_req, mem_re, mem_addr, bank_we,
//                  bank_addr, bank_din; samples mem_gnt, mem_rdata.
// slave  (memory/banks): the reverse.
interface gpu_rect_loader_if;
  import gpu_rect_loader_pkg::*;

  logic                        mem_req;
  logic                        mem_gnt;
  logic                        mem_re;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]       mem_rdata;
  logic [FIELDS-1:0]           bank_we;
  logic [RECT_COUNT_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0]       bank_din;

  modport master (
    output mem_req, mem_re, mem_addr, bank_we, bank_addr, bank_din,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_re, mem_addr, bank_we, bank_addr, bank_din,
    output mem_gnt, mem_rdata
  );

endinterface

// File: rtl/gpu_rect_loader_addr_gen.sv
// gpu_load_addr_gen
// Field/rect/address counters for the loader. All three advance
// together on adv_i (one granted read) and hold otherwise.
// Ports: clk, rst_n (sync, active-low); load_i restarts at rect 0
// field 0 / GPU_RECT_BASE; adv_i steps; rect_limit_i is the number of
// rects in this load; field_o/rect_o/addr_o are the current read;
// last_o flags that the current read is the final one.
module gpu_load_addr_gen
  import gpu_rect_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic                        adv_i,
  input  logic [RECT_COUNT_WIDTH:0]   rect_limit_i,
  output logic [FIELD_WIDTH-1:0]      field_o,
  output logic [RECT_COUNT_WIDTH-1:0] rect_o,
  output logic [MEM_ADDR_WIDTH-1:0]   addr_o,
  output logic                        last_o
);
  localparam int RCW = RECT_COUNT_WIDTH + 1;

  logic [FIELD_WIDTH-1:0]    field_q;
  logic [RCW-1:0]            rect_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic                      field_wrap;

  assign field_wrap = (field_q == FIELD_WIDTH'(FIELDS - 1));

  // The extra rect bit lets the terminal compare reach rect_limit_i = RECT_COUNT.
  assign last_o  = field_wrap && ((rect_q + RCW'(1)) == rect_limit_i);
  assign field_o = field_q;
  assign rect_o  = rect_q[RECT_COUNT_WIDTH-1:0];
  assign addr_o  = addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n || load_i) begin
      field_q <= '0;
      rect_q  <= '0;
      addr_q  <= GPU_RECT_BASE;
    end else if (adv_i) begin
      addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
      if (field_wrap) begin
        field_q <= '0;
        rect_q  <= rect_q + RCW'(1);
      end else begin
        field_q <= field_q + FIELD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gpu_rect_loader.sv
// gpu_rect_loader
// Per-frame copy engine: on start_i, reads the rectangle table
// (rect-major, fields x,y,w,h,color) from data memory and writes each
// word into the matching attribute bank one cycle after its read.
// Ports: clk, rst_n (sync, active-low); start_i frame-start pulse;
// busy_o load in progress; done_o one-cycle pulse after the last
// write; bus (master) memory read port and bank write port.
// Build option GPU_LOADER_COUNT_EN: adds rect_count_i, sampled at an
// accepted start, limiting the load to the first rect_count_i rects
// (clamped to RECT_COUNT; zero goes straight to done).
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | requesting the port, one read per granted cycle
// DRAIN | last read issued, its bank write happens this cycle
// FIN   | done pulse, back to IDLE
module gpu_rect_loader
  import gpu_rect_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
`ifdef GPU_LOADER_COUNT_EN
  input  logic [RECT_COUNT_WIDTH:0] rect_count_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  gpu_rect_loader_if.master         bus
);
  localparam int RCW = RECT_COUNT_WIDTH + 1;

  load_state_e                 state_q;
  logic                        busy_q, done_q, req_q;
  logic                        wr_valid_q;
  field_e                      wr_field_q;
  logic [RECT_COUNT_WIDTH-1:0] wr_rect_q;

  logic [FIELD_WIDTH-1:0]      cur_field;
  logic [RECT_COUNT_WIDTH-1:0] cur_rect;
  logic                        last_read;
  logic                        accept;
  logic                        mem_re;
  logic [RCW-1:0]              rect_limit;
  logic                        load_empty;

  assign accept = (state_q == IDLE) && start_i;

`ifdef GPU_LOADER_COUNT_EN
  logic [RCW-1:0] limit_d, limit_q;

  assign limit_d    = (rect_count_i > RCW'(RECT_COUNT)) ? RCW'(RECT_COUNT) : rect_count_i;
  assign load_empty = (limit_d == '0);
  assign rect_limit = limit_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      limit_q <= RCW'(RECT_COUNT);
    else if (accept) limit_q <= limit_d;
  end
`else
  assign load_empty = 1'b0;
  assign rect_limit = RCW'(RECT_COUNT);
`endif

  // Grant can drop on any cycle, so the strobe is gated combinationally.
  assign mem_re = req_q && bus.mem_gnt;

  gpu_load_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (accept),
    .adv_i        (mem_re),
    .rect_limit_i (rect_limit),
    .field_o      (cur_field),
    .rect_o       (cur_rect),
    .addr_o       (bus.mem_addr),
    .last_o       (last_read)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_field_q <= F_X;
      wr_rect_q  <= '0;
    end else begin
      wr_valid_q <= mem_re;
      if (mem_re) begin
        wr_field_q <= field_e'(cur_field);
        wr_rect_q  <= cur_rect;
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (load_empty) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (mem_re && last_read) begin
            state_q <= DRAIN;
            req_q   <= 1'b0;
          end
        end
        DRAIN: begin
          state_q <= FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write stage: data comes straight from the memory, one cycle after mem_re.
  assign bus.bank_we   = wr_valid_q ? field_onehot(wr_field_q) : '0;
  assign bus.bank_addr = wr_rect_q;
  assign bus.bank_din  = bus.mem_rdata;
  assign bus.mem_req   = req_q;
  assign bus.mem_re    = mem_re;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_gpu_rect_loader.sv
module tb_gpu_rect_loader;
  import gpu_rect_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic gnt   = 1'b1;
  logic busy, done;
`ifdef GPU_LOADER_COUNT_EN
  logic [RECT_COUNT_WIDTH:0] rect_count = 7'd64;
`endif

  gpu_rect_loader_if bus();

  gpu_rect_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
`ifdef GPU_LOADER_COUNT_EN
    .rect_count_i (rect_count),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .bus          (bus)
  );

  // Data memory: word = address, read data one cycle after mem_re.
  logic [DATA_WIDTH-1:0] rdata_q = '0;
  assign bus.mem_gnt   = gnt;
  assign bus.mem_rdata = rdata_q;
  always @(posedge clk) if (bus.mem_re) rdata_q <= bus.mem_addr;

  // Attribute banks.
  logic [DATA_WIDTH-1:0] bank_m [FIELDS][RECT_COUNT];
  logic clr = 1'b0;
  always @(posedge clk) begin
    if (clr) begin
      for (int f = 0; f < FIELDS; f++)
        for (int r = 0; r < RECT_COUNT; r++) bank_m[f][r] <= 16'hDEAD;
    end else begin
      for (int f = 0; f < FIELDS; f++)
        if (bus.bank_we[f]) bank_m[f][bus.bank_addr] <= bus.bank_din;
    end
  end

  int n_cmp = 0, n_err = 0;
  int cyc, n_rd, n_wr, n_done, first_rd, last_rd, first_wr, last_wr, first_done, last_done;
  int prev_idx, busy_lo, busy_hi, gnt_mode;
  bit prev_re, chk_busy;
  logic [MEM_ADDR_WIDTH-1:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    cyc = 0; n_rd = 0; n_wr = 0; n_done = 0;
    first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
    first_done = -1; last_done = -1;
    exp_addr = GPU_RECT_BASE; prev_re = 0; prev_idx = 0;
    chk_busy = 0; busy_lo = 1; busy_hi = 0; gnt_mode = 0;
  endtask

  task automatic observe();
    chk("re_gated", 32'(!bus.mem_re || (bus.mem_req && bus.mem_gnt)), 1);
    chk("we_onehot0", 32'($onehot0(bus.bank_we)), 1);
    if (prev_re) begin
      chk("we_field", bus.bank_we, 32'(1) << (prev_idx % FIELDS));
      chk("we_rect", bus.bank_addr, prev_idx / FIELDS);
      chk("we_data", bus.bank_din, 32'(GPU_RECT_BASE) + prev_idx);
    end else begin
      chk("we_idle", bus.bank_we, 0);
    end
    if (bus.bank_we != '0) begin
      n_wr++; if (first_wr < 0) first_wr = cyc; last_wr = cyc;
    end
    if (done) begin
      n_done++; if (first_done < 0) first_done = cyc; last_done = cyc;
    end
    if (chk_busy) chk("busy", busy, 32'(cyc >= busy_lo && cyc <= busy_hi));
    prev_re = bus.mem_re && rst_n;
    if (bus.mem_re) begin
      chk("rd_addr", bus.mem_addr, exp_addr);
      n_rd++; if (first_rd < 0) first_rd = cyc; last_rd = cyc;
      prev_idx = int'(exp_addr - GPU_RECT_BASE);
      exp_addr = exp_addr + 16'd1;
      if (exp_addr == GPU_RECT_BASE + 16'd320) exp_addr = GPU_RECT_BASE;
    end
  endtask

  task automatic step(input logic st, input logic rn);
    @(negedge clk);
    start = st;
    rst_n = rn;
    gnt = (gnt_mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    #1;
    observe();
    cyc++;
  endtask

  task automatic run_to(input int last);
    while (cyc <= last) step(1'b0, 1'b1);
  endtask

  task automatic clear_banks();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic check_banks(input string tag, input int n_new);
    for (int i = 0; i < RECT_COUNT * FIELDS; i++)
      chk(tag, bank_m[i % FIELDS][i / FIELDS],
          (i < n_new) ? 32'(GPU_RECT_BASE) + i : 32'hDEAD);
  endtask

  initial begin
    // Reset state
    begin_test();
    repeat (3) step(1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_addr", bus.mem_addr, 32'hF000);
    chk("rst_we", bus.bank_we, 0);
    chk("rst_baddr", bus.bank_addr, 0);
    repeat (2) step(1'b0, 1'b1);

    // Full load, grant always high
    clear_banks();
    begin_test();
    chk_busy = 1; busy_lo = 1; busy_hi = 321;
    step(1'b1, 1'b1);
    run_to(330);
    chk("t1_reads", n_rd, 320);
    chk("t1_first_rd", first_rd, 1);
    chk("t1_last_rd", last_rd, 320);
    chk("t1_writes", n_wr, 320);
    chk("t1_first_wr", first_wr, 2);
    chk("t1_last_wr", last_wr, 321);
    chk("t1_ndone", n_done, 1);
    chk("t1_done_cyc", first_done, 322);
    check_banks("t1_bank", 320);

    // Grant pattern 1,0,0,1
    clear_banks();
    begin_test();
    gnt_mode = 1;
    step(1'b1, 1'b1);
    while (n_done == 0 && cyc < 1000) step(1'b0, 1'b1);
    run_to(cyc + 5);
    chk("t2_ndone", n_done, 1);
    chk("t2_done_cyc", first_done, 642);
    chk("t2_reads", n_rd, 320);
    chk("t2_writes", n_wr, 320);
    chk("t2_last_rd", last_rd, 640);
    check_banks("t2_bank", 320);
    gnt_mode = 0;

    // Start re-pulsed mid-load and in FIN (ignored), then accepted at 323
    clear_banks();
    begin_test();
    while (cyc <= 700)
      step((cyc == 0 || cyc == 100 || cyc == 322 || cyc == 323), 1'b1);
    chk("t3_ndone", n_done, 2);
    chk("t3_done1", first_done, 322);
    chk("t3_done2", last_done, 645);
    chk("t3_reads", n_rd, 640);
    chk("t3_writes", n_wr, 640);
    check_banks("t3_bank", 320);

    // Reset for one cycle at cycle 50
    clear_banks();
    begin_test();
    step(1'b1, 1'b1);
    while (cyc < 50) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("t4_busy", busy, 0);
    chk("t4_req", bus.mem_req, 0);
    chk("t4_addr", bus.mem_addr, 32'hF000);
    chk("t4_we", bus.bank_we, 0);
    run_to(80);
    chk("t4_reads", n_rd, 50);
    chk("t4_writes", n_wr, 49);
    chk("t4_ndone", n_done, 0);
    check_banks("t4_bank", 49);

`ifdef GPU_LOADER_COUNT_EN
    // rect_count = 0
    rect_count = 7'd0;
    begin_test();
    chk_busy = 1; busy_lo = 1; busy_hi = 0;
    step(1'b1, 1'b1);
    run_to(10);
    chk("c0_done_cyc", first_done, 1);
    chk("c0_ndone", n_done, 1);
    chk("c0_reads", n_rd, 0);

    // rect_count = 3
    rect_count = 7'd3;
    clear_banks();
    begin_test();
    chk_busy = 1; busy_lo = 1; busy_hi = 16;
    step(1'b1, 1'b1);
    run_to(30);
    chk("c3_writes", n_wr, 15);
    chk("c3_last_wr", last_wr, 16);
    chk("c3_done_cyc", first_done, 17);
    check_banks("c3_bank", 15);

    // rect_count = 100 clamps to 64
    rect_count = 7'd100;
    clear_banks();
    begin_test();
    step(1'b1, 1'b1);
    run_to(330);
    chk("c100_reads", n_rd, 320);
    chk("c100_done_cyc", first_done, 322);
    check_banks("c100_bank", 320);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
